// File: rtl/axil_seq_master.sv
// AXI4-Lite register-bank self-test master: writes an incrementing pattern to
// C_NUM_REGS consecutive registers, reads them back, and reports pass/err_cnt.
module axil_seq_master #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                   C_NUM_REGS         = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
  parameter logic [31:0]                   C_START_DATA       = 32'h0000_0001,
  parameter logic [31:0]                   C_RD_XOR_MASK      = 32'h0000_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [7:0]                      err_cnt,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_FIN} state_t;

  localparam logic [7:0] LAST_IDX = 8'(C_NUM_REGS - 1);

  state_t      state, state_next;
  logic [7:0]  idx;
  logic        issued;
  logic        last, err_inc;
  logic [7:0]  err_next;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [31:0] pattern;

  assign M_AXI_AWPROT = '0;
  assign M_AXI_ARPROT = '0;
  assign M_AXI_WSTRB  = '1;

  assign aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs    = M_AXI_BVALID  & M_AXI_BREADY;
  assign ar_hs   = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs    = M_AXI_RVALID  & M_AXI_RREADY;
  assign last    = (idx == LAST_IDX);
  assign pattern = C_START_DATA + 32'(idx);

  assign busy = (state == S_WR) || (state == S_WR_RESP) || (state == S_RD) || (state == S_RD_DATA);
  assign done = (state == S_FIN);

  assign err_next = (err_inc && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

  always_comb begin
    state_next = state;
    err_inc    = 1'b0;
    case (state)
      S_IDLE:    if (start) state_next = S_WR;
      // AW and W complete independently; a channel is finished once its VALID has dropped
      S_WR:      if (issued && (!M_AXI_AWVALID || aw_hs) && (!M_AXI_WVALID || w_hs))
                   state_next = S_WR_RESP;
      S_WR_RESP: if (b_hs) begin
                   err_inc    = (M_AXI_BRESP != 2'b00);
                   state_next = last ? S_RD : S_WR;
                 end
      S_RD:      if (ar_hs) state_next = S_RD_DATA;
      S_RD_DATA: if (r_hs) begin
                   err_inc    = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != (pattern ^ C_RD_XOR_MASK));
                   state_next = last ? S_FIN : S_RD;
                 end
      S_FIN:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= S_IDLE;
      idx           <= '0;
      issued        <= 1'b0;
      err_cnt       <= '0;
      pass          <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (start) begin
          idx     <= '0;
          err_cnt <= '0;
          pass    <= 1'b0;
          issued  <= 1'b0;
        end
        S_WR: begin
          if (!issued) begin
            issued        <= 1'b1;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_AWADDR  <= C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});
            M_AXI_WDATA   <= pattern;
          end else begin
            if (aw_hs) M_AXI_AWVALID <= 1'b0;
            if (w_hs)  M_AXI_WVALID  <= 1'b0;
            if (state_next == S_WR_RESP) begin
              issued       <= 1'b0;
              M_AXI_BREADY <= 1'b1;
            end
          end
        end
        S_WR_RESP: if (b_hs) begin
          M_AXI_BREADY <= 1'b0;
          err_cnt      <= err_next;
          idx          <= last ? '0 : idx + 8'd1;
        end
        S_RD: begin
          if (!issued) begin
            issued        <= 1'b1;
            M_AXI_ARVALID <= 1'b1;
            M_AXI_ARADDR  <= C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});
          end else if (ar_hs) begin
            issued        <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
          end
        end
        S_RD_DATA: if (r_hs) begin
          M_AXI_RREADY <= 1'b0;
          err_cnt      <= err_next;
          if (last) pass <= (err_next == 8'd0);
          else      idx  <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_seq_master.sv
// Bench for axil_seq_master: two DUTs (default and inverted/wrapping pattern)
// driven by a configurable AXI4-Lite memory slave and checked against a model.
module tb_axil_seq_master;

  localparam int N = 4;
  localparam logic [31:0] SD [2] = '{32'h0000_0001, 32'hFFFF_FFFF};
  localparam logic [31:0] MK [2] = '{32'h0000_0000, 32'hFFFF_FFFF};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start [2], busy [2], done [2], pass [2];
  logic [7:0]  err_cnt [2];
  logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
  logic [2:0]  awprot [2], arprot [2];
  logic [3:0]  wstrb [2];
  logic [1:0]  bresp [2], rresp [2];
  logic        awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
  logic        arvalid [2], arready [2], rvalid [2], rready [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axil_seq_master #(
      .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_NUM_REGS(N),
      .C_BASE_ADDR(32'h0), .C_START_DATA(SD[g]), .C_RD_XOR_MASK(MK[g])
    ) u_dut (
      .ACLK(clk), .ARESET(rst), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .pass(pass[g]), .err_cnt(err_cnt[g]),
      .M_AXI_AWADDR(awaddr[g]), .M_AXI_AWPROT(awprot[g]), .M_AXI_AWVALID(awvalid[g]),
      .M_AXI_AWREADY(awready[g]), .M_AXI_WDATA(wdata[g]), .M_AXI_WSTRB(wstrb[g]),
      .M_AXI_WVALID(wvalid[g]), .M_AXI_WREADY(wready[g]), .M_AXI_BRESP(bresp[g]),
      .M_AXI_BVALID(bvalid[g]), .M_AXI_BREADY(bready[g]), .M_AXI_ARADDR(araddr[g]),
      .M_AXI_ARPROT(arprot[g]), .M_AXI_ARVALID(arvalid[g]), .M_AXI_ARREADY(arready[g]),
      .M_AXI_RDATA(rdata[g]), .M_AXI_RRESP(rresp[g]), .M_AXI_RVALID(rvalid[g]),
      .M_AXI_RREADY(rready[g])
    );
  end

  // slave configuration, written only by the stimulus process
  int unsigned aw_dly [2], w_dly [2], ar_dly [2];
  logic        stall [2], invert [2];
  int          berr_idx [2], rbad_idx [2];

  // slave state and monitors
  logic [31:0] mem [2][64];
  logic [31:0] cap_addr [2], cap_data [2], waddr_eff [2], wdat_eff [2];
  logic [31:0] prev_awaddr [2], prev_wdata [2];
  logic        got_aw [2], got_w [2], hold_aw [2], hold_w [2];
  logic        aw_hs [2], w_hs [2], b_hs [2], ar_hs [2], r_hs [2];
  int unsigned aw_wait [2], w_wait [2], ar_wait [2];
  int unsigned wr_n [2], aw_n [2], w_n [2], ar_n [2], done_n [2], stab_err [2];
  logic [31:0] wa_log [2][256], wd_log [2][256], ra_log [2][256];

  // odd-numbered writes swap the AW/W ready delays
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      awready[g]   = awvalid[g] && !stall[g] && aw_wait[g] >= ((wr_n[g] % 2 == 1) ? w_dly[g] : aw_dly[g]);
      wready[g]    = wvalid[g] && !stall[g] && w_wait[g] >= ((wr_n[g] % 2 == 1) ? aw_dly[g] : w_dly[g]);
      arready[g]   = arvalid[g] && ar_wait[g] >= ar_dly[g];
      aw_hs[g]     = awvalid[g] && awready[g];
      w_hs[g]      = wvalid[g] && wready[g];
      b_hs[g]      = bvalid[g] && bready[g];
      ar_hs[g]     = arvalid[g] && arready[g];
      r_hs[g]      = rvalid[g] && rready[g];
      waddr_eff[g] = aw_hs[g] ? awaddr[g] : cap_addr[g];
      wdat_eff[g]  = w_hs[g] ? wdata[g] : cap_data[g];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        bvalid[g] <= 1'b0; rvalid[g] <= 1'b0; bresp[g] <= 2'b00; rresp[g] <= 2'b00;
        rdata[g] <= '0; got_aw[g] <= 1'b0; got_w[g] <= 1'b0;
        hold_aw[g] <= 1'b0; hold_w[g] <= 1'b0;
        aw_wait[g] <= 0; w_wait[g] <= 0; ar_wait[g] <= 0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        aw_wait[g] <= (awvalid[g] && !aw_hs[g]) ? aw_wait[g] + 1 : 0;
        w_wait[g]  <= (wvalid[g] && !w_hs[g]) ? w_wait[g] + 1 : 0;
        ar_wait[g] <= (arvalid[g] && !ar_hs[g]) ? ar_wait[g] + 1 : 0;
        if (aw_hs[g]) begin cap_addr[g] <= awaddr[g]; aw_n[g] <= aw_n[g] + 1; end
        if (w_hs[g])  begin cap_data[g] <= wdata[g];  w_n[g]  <= w_n[g] + 1;  end
        if ((got_aw[g] || aw_hs[g]) && (got_w[g] || w_hs[g])) begin
          mem[g][waddr_eff[g][7:2]] <= wdat_eff[g];
          wa_log[g][wr_n[g] % 256]  <= waddr_eff[g];
          wd_log[g][wr_n[g] % 256]  <= wdat_eff[g];
          wr_n[g]   <= wr_n[g] + 1;
          bvalid[g] <= 1'b1;
          bresp[g]  <= (int'(waddr_eff[g][7:2]) == berr_idx[g]) ? 2'b10 : 2'b00;
          got_aw[g] <= 1'b0;
          got_w[g]  <= 1'b0;
        end else begin
          if (aw_hs[g]) got_aw[g] <= 1'b1;
          if (w_hs[g])  got_w[g]  <= 1'b1;
        end
        if (b_hs[g]) bvalid[g] <= 1'b0;
        if (ar_hs[g]) begin
          ra_log[g][ar_n[g] % 256] <= araddr[g];
          ar_n[g]   <= ar_n[g] + 1;
          rvalid[g] <= 1'b1;
          rdata[g]  <= (int'(araddr[g][7:2]) == rbad_idx[g]) ? 32'h0000_0005 :
                       (invert[g] ? ~mem[g][araddr[g][7:2]] : mem[g][araddr[g][7:2]]);
        end else if (r_hs[g]) begin
          rvalid[g] <= 1'b0;
        end
        if (done[g]) done_n[g] <= done_n[g] + 1;
        hold_aw[g]     <= awvalid[g] && !awready[g];
        hold_w[g]      <= wvalid[g] && !wready[g];
        prev_awaddr[g] <= awaddr[g];
        prev_wdata[g]  <= wdata[g];
        if ((hold_aw[g] && (!awvalid[g] || awaddr[g] != prev_awaddr[g])) ||
            (hold_w[g] && (!wvalid[g] || wdata[g] != prev_wdata[g])))
          stab_err[g] <= stab_err[g] + 1;
      end
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cfg(input int g, input int unsigned awd, input int unsigned wd, input int unsigned ard,
                     input logic inv, input int berr, input int rbad);
    aw_dly[g] = awd; w_dly[g] = wd; ar_dly[g] = ard;
    invert[g] = inv; berr_idx[g] = berr; rbad_idx[g] = rbad; stall[g] = 1'b0;
  endtask

  // expected error count from the register-bank rules alone
  function automatic int model_err(input int g);
    int e = 0;
    logic [31:0] wv, rv;
    for (int i = 0; i < N; i++) begin
      wv = SD[g] + 32'(i);
      if (i == berr_idx[g]) e++;
      rv = (i == rbad_idx[g]) ? 32'h0000_0005 : (invert[g] ? ~wv : wv);
      if (rv != (wv ^ MK[g])) e++;
    end
    return (e > 255) ? 255 : e;
  endfunction

  task automatic run_and_check(input int g, input string nm, input int exp_err,
                               input logic exp_pass, input int exp_cyc);
    int unsigned wb, rb, an0, wn0, se0;
    int cyc, bad;
    wb = wr_n[g]; rb = ar_n[g]; an0 = aw_n[g]; wn0 = w_n[g]; se0 = stab_err[g];
    @(negedge clk); start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0;
    check({nm, "_busy"}, 64'(busy[g]), 64'd1);
    cyc = 0;
    while (!done[g] && cyc < 2000) begin @(negedge clk); cyc++; end
    check({nm, "_done"}, 64'(done[g]), 64'd1);
    if (exp_cyc > 0) check({nm, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({nm, "_err_cnt"}, 64'(err_cnt[g]), 64'(exp_err));
    check({nm, "_pass"}, 64'(pass[g]), 64'(exp_pass));
    check({nm, "_busy_at_done"}, 64'(busy[g]), 64'd0);
    check({nm, "_hs_counts"}, {16'(aw_n[g] - an0), 16'(w_n[g] - wn0), 16'(ar_n[g] - rb)},
          {16'(N), 16'(N), 16'(N)});
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (wa_log[g][(wb + i) % 256] !== 32'(4 * i)) bad++;
      if (wd_log[g][(wb + i) % 256] !== SD[g] + 32'(i)) bad++;
      if (ra_log[g][(rb + i) % 256] !== 32'(4 * i)) bad++;
    end
    check({nm, "_addr_data"}, 64'(bad), 64'd0);
    check({nm, "_stable"}, 64'(stab_err[g] - se0), 64'd0);
    @(negedge clk);
    check({nm, "_done_pulse"}, 64'(done[g]), 64'd0);
    check({nm, "_pass_held"}, 64'(pass[g]), 64'(exp_pass));
  endtask

  typedef struct {
    int          g;
    int unsigned awd, wd, ard;
    logic        inv;
    int          berr, rbad;
    int          exp_err;
    logic        exp_pass;
    int          exp_cyc;
    string       name;
  } vec_t;

  vec_t vt [7];

  initial begin
    int d0, k, cyc, gsel;
    vt[0] = '{0, 0, 0, 0, 1'b0, -1, -1, 0, 1'b1, 24, "zero_wait"};
    vt[1] = '{0, 0, 3, 0, 1'b0, -1, -1, 0, 1'b1, 0, "aw_before_w"};
    vt[2] = '{0, 3, 0, 2, 1'b0, -1, -1, 0, 1'b1, 0, "w_before_aw"};
    vt[3] = '{0, 0, 0, 0, 1'b0, -1, 2, 1, 1'b0, 0, "bad_rdata"};
    vt[4] = '{0, 0, 0, 0, 1'b0, 1, -1, 1, 1'b0, 0, "slverr"};
    vt[5] = '{1, 0, 0, 0, 1'b1, -1, -1, 0, 1'b1, 0, "mask_invert"};
    vt[6] = '{1, 1, 0, 1, 1'b0, -1, -1, 4, 1'b0, 0, "mask_plain"};

    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0;
      cfg(g, 0, 0, 0, 1'b0, -1, -1);
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_valids", 64'({awvalid[g], wvalid[g], bready[g], arvalid[g], rready[g]}), 64'd0);
      check("rst_status", 64'({busy[g], done[g], pass[g]}), 64'd0);
      check("rst_err_cnt", 64'(err_cnt[g]), 64'd0);
      check("rst_addr_data", {awaddr[g], wdata[g]}, 64'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      cfg(vt[i].g, vt[i].awd, vt[i].wd, vt[i].ard, vt[i].inv, vt[i].berr, vt[i].rbad);
      run_and_check(vt[i].g, vt[i].name, vt[i].exp_err, vt[i].exp_pass, vt[i].exp_cyc);
    end
    check("const_prot_strb", 64'({awprot[0], arprot[0], wstrb[0]}), 64'h00F);

    // asynchronous reset while the slave stalls the write address/data
    cfg(0, 0, 0, 0, 1'b0, -1, -1);
    stall[0] = 1'b1;
    d0 = int'(done_n[0]);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    cyc = 0;
    while (!awvalid[0] && cyc < 20) begin @(negedge clk); cyc++; end
    check("abort_awvalid_seen", 64'(awvalid[0]), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_valids", 64'({awvalid[0], wvalid[0], arvalid[0], bready[0], rready[0]}), 64'd0);
    check("abort_busy", 64'(busy[0]), 64'd0);
    @(negedge clk); rst = 1'b0; stall[0] = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", 64'(int'(done_n[0]) - d0), 64'd0);
    run_and_check(0, "after_abort", 0, 1'b1, 24);

    // start during busy and on the done cycle must be ignored
    d0 = int'(done_n[0]);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (5) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    cyc = 0;
    while (!done[0] && cyc < 200) begin @(negedge clk); cyc++; end
    check("ign_done_seen", 64'(done[0]), 64'd1);
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("ign_one_done", 64'(int'(done_n[0]) - d0), 64'd1);
    check("ign_idle", 64'(busy[0]), 64'd0);

    // randomized slave timing and fault injection against the model
    for (k = 0; k < 10; k++) begin
      gsel = int'($urandom_range(0, 1));
      cfg(gsel, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 5)) - 1, int'($urandom_range(0, 5)) - 1);
      run_and_check(gsel, "rnd", model_err(gsel), model_err(gsel) == 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/axil_seq_master.md
Name: axil_seq_master

Overview:
- AXI4-Lite master engine that exercises a peripheral's register bank in hardware.
- On a start pulse it writes an incrementing pattern to C_NUM_REGS consecutive 32-bit registers, then reads each one back and compares it against the expected value.
- It reports done, pass and an error count.
- It sits directly upstream of the inv AXI4-Lite slave and drives its S_AXI port, for on-board self-test after partial reconfiguration.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 supported.
- C_NUM_REGS, 4, number of registers written/read (1..256).
- C_BASE_ADDR, 0x00000000, address of register 0; register i at C_BASE_ADDR + 4*i.
- C_START_DATA, 0x00000001, data written to register 0; register i gets C_START_DATA + i, modulo 2^32.
- C_RD_XOR_MASK, 0x00000000, expected readback = written XOR mask (covers slaves that invert on read).

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the sequence completes
- pass  out  1  valid from done; 1 iff err_cnt==0; held until next accepted start
- err_cnt  out  8  saturating count of failed responses/compares
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH
- M_AXI_AWPROT  out  3  constant 0
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32
- M_AXI_WSTRB  out  4  constant 4'hF
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH
- M_AXI_ARPROT  out  3  constant 0
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset values: all VALID/READY outputs 0, busy 0, done 0, pass 0, err_cnt 0, addresses/data 0, index 0, state IDLE.
- State IDLE: start=1 registers index=0 and clears err_cnt and pass, then goes to WR.
- State WR:
  - AWVALID and WVALID rise together, with AWADDR = C_BASE_ADDR + 4*index and WDATA = C_START_DATA + index.
  - Each VALID drops the cycle after its own handshake (VALID&READY); the two may complete in either order or in the same cycle.
  - AWADDR/WDATA are stable while their VALID is high.
  - Once both handshakes are done, go to WR_RESP.
- State WR_RESP:
  - BREADY=1.
  - On BVALID: if BRESP!=2'b00, err_cnt+1.
  - If index==C_NUM_REGS-1, set index=0 and go to RD; else index+1 and go to WR.
  - BREADY drops the cycle after the handshake.
- State RD: ARVALID=1 with ARADDR = C_BASE_ADDR + 4*index, held until ARREADY; then go to RD_DATA.
- State RD_DATA:
  - RREADY=1.
  - On RVALID: error (err_cnt+1, at most one increment per beat) if RRESP!=0 or RDATA != ((C_START_DATA+index) XOR C_RD_XOR_MASK).
  - If index==C_NUM_REGS-1, go to FIN; else index+1 and go to RD.
- State FIN: done=1 for exactly one cycle, busy=0, pass=(err_cnt==0) using the final count including the last beat; return to IDLE.
- Only one outstanding transaction at any time; no write/read overlap.
- err_cnt saturates at 255.
- Handshake latency: zero-wait slave gives 3 cycles per write (WR→WR_RESP→next) and 3 per read.
- start asserted in the same cycle as done/FIN is ignored; it is accepted only in IDLE.
- ARESET mid-transaction: all VALIDs drop asynchronously and the sequence aborts; no done pulse; the slave is assumed to be reset by the same reset.
- A slave holding READY low indefinitely stalls the engine; there is no timeout.

Test Plan:
- Defaults, zero-wait slave with memory model; pulse start → writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then 4 reads; done after 24 cycles, pass=1, err_cnt=0.
- Slave asserts AWREADY 3 cycles before WREADY, and vice versa on the next write → each address/data is accepted exactly once; WDATA stable while WVALID; pass=1.
- Slave returns RDATA 0x00000005 at 0x8 → err_cnt=1, pass=0; BRESP=SLVERR on the 2nd write in a separate run → err_cnt=1.
- C_RD_XOR_MASK=0xFFFFFFFF against an inverting slave (reads ~written) → pass=1; same mask against a plain memory → err_cnt=4.
- Assert ARESET while AWVALID=1 and the slave is stalled → all VALIDs 0 within the same cycle, busy=0, no done; a new start completes normally with pass=1.
- start pulsed during busy and on the done cycle → ignored; exactly one done per accepted start; C_START_DATA=0xFFFFFFFF writes 0xFFFFFFFF then 0x00000000 (wrap).
